// File: rtl/alu_serial_core.sv
// alu_serial_core: byte-serial multi-cycle integer ALU for the tt_um ALU tile.
// A frame is one opcode byte, A and B LSB first, then the result LSB first and a status byte.
module alu_serial_core #(
  parameter int W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int NB   = W / 8;
  localparam int SH_W = $clog2(W);
  localparam logic [3:0] LAST_IDX   = 4'(NB - 1);
  localparam logic [3:0] STATUS_IDX = 4'(NB);
  localparam logic [6:0] MUL_LAST   = 7'(W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EXEC   = 3'd3,
    SEND   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_MUL = 3'd5,
    OP_SHL = 3'd6,
    OP_CMP = 3'd7
  } op_t;

  function automatic logic [W-1:0] put_byte(input logic [W-1:0] v, input logic [3:0] idx,
                                            input logic [7:0] d);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NB; i++) begin
      if (idx == 4'(i)) begin
        r[i*8 +: 8] = d;
      end else begin
        r[i*8 +: 8] = v[i*8 +: 8];
      end
    end
    return r;
  endfunction

  // Byte idx of the result, or the status byte once idx reaches NB
  function automatic logic [7:0] send_byte(input logic [W-1:0] res, input logic [7:0] status,
                                           input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (idx == 4'(i)) begin
        r = res[i*8 +: 8];
      end else begin
        r = r;
      end
    end
    if (idx == STATUS_IDX) begin
      r = status;
    end else begin
      r = r;
    end
    return r;
  endfunction

  state_t         state_r, state_nxt_s;
  op_t            op_r, op_nxt_s;
  logic [3:0]     byte_cnt_r, byte_cnt_nxt_s;
  logic [6:0]     mul_cnt_r, mul_cnt_nxt_s;
  logic [W-1:0]   a_r, a_nxt_s;
  logic [W-1:0]   b_r, b_nxt_s;
  logic [2*W-1:0] acc_r, acc_nxt_s;
  logic [W-1:0]   res_r, res_nxt_s;
  logic           carry_r, carry_nxt_s;
  logic [7:0]     out_data_r, out_data_nxt_s;
  logic           out_valid_r, out_valid_nxt_s;
  logic           in_ready_r;
  logic           busy_r;

  logic           in_fire_s;
  logic [W:0]     add_s;
  logic [2*W-1:0] acc_cur_s;
  logic [W:0]     mul_sum_s;
  logic [2*W-1:0] mul_step_s;
  logic [W-1:0]   alu_res_s;
  logic           alu_c_s;
  logic [7:0]     status_s;

  assign in_fire_s = in_valid & in_ready_r;
  assign add_s     = {1'b0, a_r} + {1'b0, b_r};
  assign status_s  = {5'b00000, carry_r, res_r[W-1], (res_r == {W{1'b0}})};

  // One shift-add step: accumulator starts as {0, B}, A is added into the upper half when bit 0 is set
  assign acc_cur_s  = (mul_cnt_r == 7'd0) ? {{W{1'b0}}, b_r} : acc_r;
  assign mul_sum_s  = {1'b0, acc_cur_s[2*W-1:W]} + (acc_cur_s[0] ? {1'b0, a_r} : {(W+1){1'b0}});
  assign mul_step_s = {mul_sum_s, acc_cur_s[W-1:1]};

  // Result and carry of the latched opcode; MUL is only meaningful on its final step
  always_comb begin
    alu_res_s = {W{1'b0}};
    alu_c_s   = 1'b0;
    case (op_r)
      OP_ADD: begin
        alu_res_s = add_s[W-1:0];
        alu_c_s   = add_s[W];
      end
      OP_SUB: begin
        alu_res_s = a_r - b_r;
        alu_c_s   = (a_r < b_r);
      end
      OP_AND: alu_res_s = a_r & b_r;
      OP_OR:  alu_res_s = a_r | b_r;
      OP_XOR: alu_res_s = a_r ^ b_r;
      OP_MUL: begin
        alu_res_s = mul_step_s[W-1:0];
        alu_c_s   = (mul_step_s[2*W-1:W] != {W{1'b0}});
      end
      OP_SHL: alu_res_s = a_r << b_r[SH_W-1:0];
      OP_CMP: begin
        alu_res_s[0] = (a_r == b_r);
        alu_res_s[1] = (a_r < b_r);
        alu_res_s[2] = ($signed(a_r) < $signed(b_r));
      end
      default: begin
        alu_res_s = {W{1'b0}};
        alu_c_s   = 1'b0;
      end
    endcase
  end

  // Next-state and next-register logic of the frame FSM
  always_comb begin
    state_nxt_s     = state_r;
    op_nxt_s        = op_r;
    byte_cnt_nxt_s  = byte_cnt_r;
    mul_cnt_nxt_s   = mul_cnt_r;
    a_nxt_s         = a_r;
    b_nxt_s         = b_r;
    acc_nxt_s       = acc_r;
    res_nxt_s       = res_r;
    carry_nxt_s     = carry_r;
    out_data_nxt_s  = out_data_r;
    out_valid_nxt_s = out_valid_r;
    case (state_r)
      IDLE: begin
        if (in_fire_s) begin
          op_nxt_s       = op_t'(in_data[2:0]);
          byte_cnt_nxt_s = 4'd0;
          state_nxt_s    = LOAD_A;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_A: begin
        if (in_fire_s) begin
          a_nxt_s = put_byte(a_r, byte_cnt_r, in_data);
          if (byte_cnt_r == LAST_IDX) begin
            byte_cnt_nxt_s = 4'd0;
            state_nxt_s    = LOAD_B;
          end else begin
            byte_cnt_nxt_s = byte_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = LOAD_A;
        end
      end
      LOAD_B: begin
        if (in_fire_s) begin
          b_nxt_s = put_byte(b_r, byte_cnt_r, in_data);
          if (byte_cnt_r == LAST_IDX) begin
            byte_cnt_nxt_s = 4'd0;
            mul_cnt_nxt_s  = 7'd0;
            state_nxt_s    = EXEC;
          end else begin
            byte_cnt_nxt_s = byte_cnt_r + 4'd1;
          end
        end else begin
          state_nxt_s = LOAD_B;
        end
      end
      EXEC: begin
        if ((op_r != OP_MUL) || (mul_cnt_r == MUL_LAST)) begin
          res_nxt_s      = alu_res_s;
          carry_nxt_s    = alu_c_s;
          byte_cnt_nxt_s = 4'd0;
          mul_cnt_nxt_s  = 7'd0;
          state_nxt_s    = SEND;
        end else begin
          acc_nxt_s     = mul_step_s;
          mul_cnt_nxt_s = mul_cnt_r + 7'd1;
        end
      end
      SEND: begin
        // First SEND cycle loads byte 0; afterwards the index moves only on a transfer
        if (!out_valid_r) begin
          out_valid_nxt_s = 1'b1;
          out_data_nxt_s  = send_byte(res_r, status_s, byte_cnt_r);
        end else if (out_ready) begin
          if (byte_cnt_r == STATUS_IDX) begin
            out_valid_nxt_s = 1'b0;
            byte_cnt_nxt_s  = 4'd0;
            state_nxt_s     = IDLE;
          end else begin
            byte_cnt_nxt_s = byte_cnt_r + 4'd1;
            out_data_nxt_s = send_byte(res_r, status_s, byte_cnt_r + 4'd1);
          end
        end else begin
          out_data_nxt_s = out_data_r;
        end
      end
      default: begin
        state_nxt_s     = IDLE;
        byte_cnt_nxt_s  = 4'd0;
        mul_cnt_nxt_s   = 7'd0;
        out_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // All state, datapath and output registers; synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= OP_ADD;
      byte_cnt_r  <= 4'd0;
      mul_cnt_r   <= 7'd0;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      acc_r       <= {(2*W){1'b0}};
      res_r       <= {W{1'b0}};
      carry_r     <= 1'b0;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      op_r        <= op_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
      mul_cnt_r   <= mul_cnt_nxt_s;
      a_r         <= a_nxt_s;
      b_r         <= b_nxt_s;
      acc_r       <= acc_nxt_s;
      res_r       <= res_nxt_s;
      carry_r     <= carry_nxt_s;
      out_data_r  <= out_data_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      in_ready_r  <= (state_nxt_s == IDLE) || (state_nxt_s == LOAD_A) || (state_nxt_s == LOAD_B);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_alu_serial_core.sv
// Self-checking bench for alu_serial_core: W=32, 8 and 64 instances, directed table,
// reset corner sequences and randomized frames against an arithmetic reference model.
module tb_alu_serial_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       out_ready;
  int         sel;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic       iv32, iv8, iv64;
  logic       ir32, ir8, ir64;
  logic [7:0] od32, od8, od64;
  logic       ov32, ov8, ov64;
  logic       bz32, bz8, bz64;
  logic       in_ready_m, out_valid_m, busy_m;
  logic [7:0] out_data_m;

  assign iv32 = in_valid && (sel == 0);
  assign iv8  = in_valid && (sel == 1);
  assign iv64 = in_valid && (sel == 2);
  assign in_ready_m  = (sel == 0) ? ir32 : (sel == 1) ? ir8 : ir64;
  assign out_valid_m = (sel == 0) ? ov32 : (sel == 1) ? ov8 : ov64;
  assign busy_m      = (sel == 0) ? bz32 : (sel == 1) ? bz8 : bz64;
  assign out_data_m  = (sel == 0) ? od32 : (sel == 1) ? od8 : od64;

  alu_serial_core #(.W(32)) u32 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv32),
    .in_ready(ir32), .out_data(od32), .out_valid(ov32), .out_ready(out_ready), .busy(bz32));
  alu_serial_core #(.W(8)) u8 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv8),
    .in_ready(ir8), .out_data(od8), .out_valid(ov8), .out_ready(out_ready), .busy(bz8));
  alu_serial_core #(.W(64)) u64 (.clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(iv64),
    .in_ready(ir64), .out_data(od64), .out_valid(ov64), .out_ready(out_ready), .busy(bz64));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int width_of(input int s);
    return (s == 0) ? 32 : (s == 1) ? 8 : 64;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: plain arithmetic on wide integers, truncated to w bits
  function automatic void ref_model(input int w, input logic [2:0] op, input logic [63:0] a_in,
                                    input logic [63:0] b_in, output logic [63:0] r,
                                    output logic [7:0] st);
    logic [127:0] mask, a, b, sgn, wide;
    logic c;
    mask = (128'd1 << w) - 128'd1;
    a    = {64'd0, a_in} & mask;
    b    = {64'd0, b_in} & mask;
    sgn  = 128'd1 << (w - 1);
    c    = 1'b0;
    wide = 128'd0;
    case (op)
      3'd0: begin wide = a + b; c = wide[w]; end
      3'd1: begin wide = a - b; c = (a < b); end
      3'd2: wide = a & b;
      3'd3: wide = a | b;
      3'd4: wide = a ^ b;
      3'd5: begin wide = a * b; c = ((wide >> w) != 128'd0); end
      3'd6: wide = a << (b % w);
      default: begin
        wide[0] = (a == b);
        wide[1] = (a < b);
        wide[2] = ((a ^ sgn) < (b ^ sgn));
      end
    endcase
    wide = wide & mask;
    r    = wide[63:0];
    st   = {5'd0, c, wide[w-1], (wide == 128'd0)};
  endfunction

  task automatic push_byte(input logic [7:0] d);
    int g;
    g = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready_m && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) check("in_ready_wait", {63'd0, in_ready_m}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_frame(input int s, input logic [2:0] op, input logic [63:0] a,
                            input logic [63:0] b, input int nbytes);
    logic [4:0] junk;
    sel  = s;
    junk = 5'($urandom);
    push_byte({junk, op});
    for (int i = 0; i < nbytes; i++) begin
      if (i < width_of(s) / 8) push_byte(a[i*8 +: 8]);
      else push_byte(b[(i - width_of(s) / 8)*8 +: 8]);
    end
  endtask

  task automatic check_idle(input string name);
    check(name, {60'd0, in_ready_m, out_valid_m, busy_m, 1'b0} | {56'd0, out_data_m} << 4,
          {60'd0, 4'b1000});
  endtask

  task automatic run_frame(input int s, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp_r,
                           input logic [7:0] exp_st, input int exp_lat, input int mode,
                           input bit pulse, input string name);
    int nb, t0, g, stall_cnt;
    bit saw_ready, stalled;
    logic [7:0] held, act;
    logic [7:0] got[$];
    nb = width_of(s) / 8;
    out_ready = 1'b0;
    load_frame(s, op, a, b, 2 * nb);
    t0 = cyc;
    g = 0;
    saw_ready = 1'b0;
    while (!out_valid_m && g < 200) begin
      if (in_ready_m) saw_ready = 1'b1;
      if (pulse) begin in_valid = 1'($urandom); in_data = 8'($urandom); end
      @(negedge clk);
      g++;
    end
    check({name, ".latency"}, 64'(cyc - t0), 64'(exp_lat));
    check({name, ".busy"}, {63'd0, busy_m}, 64'd1);
    stalled = 1'b0;
    stall_cnt = 0;
    g = 0;
    while (got.size() < nb + 1 && g < 1000) begin
      if (in_ready_m) saw_ready = 1'b1;
      if (stalled) check({name, ".hold"}, {55'd0, out_valid_m, out_data_m}, {55'd0, 1'b1, held});
      if (pulse && got.size() < nb) begin
        in_valid = 1'($urandom);
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid_m) begin
        if (mode == 0) out_ready = 1'b1;
        else if (mode == 1) out_ready = (stall_cnt >= 5);
        else out_ready = 1'($urandom);
        if (out_ready) begin
          got.push_back(out_data_m);
          stalled = 1'b0;
          stall_cnt = 0;
        end else begin
          stalled = 1'b1;
          held = out_data_m;
          stall_cnt++;
        end
      end else begin
        out_ready = 1'($urandom);
        stalled = 1'b0;
      end
      @(negedge clk);
      g++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({name, ".in_ready_low"}, {63'd0, saw_ready}, 64'd0);
    check({name, ".nbytes"}, 64'(got.size()), 64'(nb + 1));
    for (int i = 0; i <= nb; i++) begin
      act = (i < got.size()) ? got[i] : 8'hxx;
      if (i < nb) check($sformatf("%s.b%0d", name, i), {56'd0, act}, {56'd0, exp_r[i*8 +: 8]});
      else check({name, ".status"}, {56'd0, act}, {56'd0, exp_st});
    end
    check({name, ".idle_after"}, {61'd0, out_valid_m, busy_m, in_ready_m}, 64'd1);
  endtask

  task automatic reset_pulse(input string name);
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_idle(name);
  endtask

  typedef struct {
    int s; logic [2:0] op; logic [63:0] a; logic [63:0] b; logic [63:0] r;
    logic [7:0] st; int lat; int mode; bit pulse;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic [63:0] a, b, r;
    logic [7:0] st;
    logic [2:0] op;
    int s, w, g;

    vecs[0]  = '{0, 3'd0, 64'hFFFFFFFF, 64'h1, 64'h0, 8'h05, 2, 0, 1'b0};
    vecs[1]  = '{0, 3'd1, 64'h3, 64'h5, 64'hFFFFFFFE, 8'h06, 2, 1, 1'b0};
    vecs[2]  = '{0, 3'd5, 64'h10000, 64'h10000, 64'h0, 8'h05, 33, 0, 1'b1};
    vecs[3]  = '{0, 3'd5, 64'd1234, 64'd5678, 64'h006AE9BC, 8'h00, 33, 0, 1'b0};
    vecs[4]  = '{0, 3'd6, 64'h1, 64'h3F, 64'h80000000, 8'h02, 2, 1, 1'b1};
    vecs[5]  = '{0, 3'd7, 64'h1, 64'hFFFFFFFF, 64'h2, 8'h00, 2, 0, 1'b0};
    vecs[6]  = '{0, 3'd7, 64'h5, 64'h5, 64'h1, 8'h00, 2, 2, 1'b0};
    vecs[7]  = '{0, 3'd2, 64'hF0F0F0F0, 64'hFF00FF00, 64'hF000F000, 8'h02, 2, 0, 1'b0};
    vecs[8]  = '{0, 3'd3, 64'h0, 64'h0, 64'h0, 8'h01, 2, 0, 1'b0};
    vecs[9]  = '{0, 3'd4, 64'h12345678, 64'hFFFFFFFF, 64'hEDCBA987, 8'h02, 2, 0, 1'b1};
    vecs[10] = '{1, 3'd0, 64'hFF, 64'h01, 64'h0, 8'h05, 2, 0, 1'b0};
    vecs[11] = '{1, 3'd5, 64'h10, 64'h10, 64'h0, 8'h05, 9, 0, 1'b0};
    vecs[12] = '{2, 3'd0, 64'hFFFFFFFFFFFFFFFF, 64'h1, 64'h0, 8'h05, 2, 1, 1'b0};
    vecs[13] = '{2, 3'd5, 64'h100000000, 64'h100000000, 64'h0, 8'h05, 65, 0, 1'b0};
    vecs[14] = '{2, 3'd6, 64'h1, 64'h3F, 64'h8000000000000000, 8'h02, 2, 0, 1'b0};
    vecs[15] = '{1, 3'd6, 64'h3, 64'h0F, 64'h80, 8'h02, 2, 0, 1'b0};
    vecs[16] = '{1, 3'd7, 64'h80, 64'h01, 64'h4, 8'h00, 2, 0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    sel = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #0 check_idle($sformatf("reset_state_w%0d", width_of(k)));
    end
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++)
      run_frame(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].st,
                vecs[i].lat, vecs[i].mode, vecs[i].pulse, $sformatf("vec%0d", i));

    // Reset after a partial load, then a clean ADD 2+3 on every width
    for (int k = 0; k < 3; k++) begin
      load_frame(k, 3'd0, 64'hA5A5, 64'h0, 2);
      reset_pulse($sformatf("rst_midload_w%0d", width_of(k)));
      run_frame(k, 3'd0, 64'd2, 64'd3, 64'd5, 8'h00, 2, 0, 1'b0,
                $sformatf("add_after_rst_w%0d", width_of(k)));
    end

    // Reset in the middle of a MUL
    load_frame(0, 3'd5, 64'h1234, 64'h5678, 8);
    repeat (5) @(negedge clk);
    reset_pulse("rst_midexec");
    run_frame(0, 3'd0, 64'd2, 64'd3, 64'd5, 8'h00, 2, 0, 1'b0, "add_after_exec_rst");

    // Reset while a result byte is stalled
    load_frame(0, 3'd1, 64'h3, 64'h5, 8);
    g = 0;
    while (!out_valid_m && g < 50) begin @(negedge clk); g++; end
    repeat (2) @(negedge clk);
    check("stalled_valid", {63'd0, out_valid_m}, 64'd1);
    reset_pulse("rst_midsend");
    run_frame(0, 3'd0, 64'd2, 64'd3, 64'd5, 8'h00, 2, 0, 1'b0, "add_after_send_rst");

    for (int k = 0; k < 60; k++) begin
      s  = (k < 36) ? 0 : (k < 48) ? 1 : 2;
      w  = width_of(s);
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 4))
        0: b = a;
        1: a = 64'hFFFFFFFFFFFFFFFF;
        2: b = 64'($urandom_range(0, 3));
        3: a = 64'h0;
        default: a = a;
      endcase
      ref_model(w, op, a, b, r, st);
      run_frame(s, op, a, b, r, st, (op == 3'd5) ? w + 1 : 2, $urandom_range(0, 2),
                1'($urandom), $sformatf("rnd%0d_w%0d_op%0d", k, w, op));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
